// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with a blocking line refill.
// A miss stalls fetch, streams WORDS beats from memory in order, installs the line, then retries.
module instr_cache #(
  parameter int SETS  = 16,
  parameter int WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic [1:0]  state_o
);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int LINE_W = TAG_W + IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILLED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [31:0]         data_q [SETS][WORDS];
  logic                data_we, tag_we;

  logic [OFF_W-1:0]    pc_off;
  logic [IDX_W-1:0]    pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [IDX_W-1:0]    line_idx;
  logic [TAG_W-1:0]    line_tag;
  logic [1:0]          pc_lsb_unused;
  logic                hit;

  assign pc_off        = pc_i[OFF_W+1:2];
  assign pc_idx        = pc_i[OFF_W+2 +: IDX_W];
  assign pc_tag        = pc_i[31 -: TAG_W];
  assign pc_lsb_unused = pc_i[1:0];
  assign line_idx      = line_q[IDX_W-1:0];
  assign line_tag      = line_q[IDX_W +: TAG_W];

  // Lookups only resolve in IDLE; REFILL and FILLED always stall an active request.
  assign hit     = req_i & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag) & (state_q == IDLE);
  assign instr_o = hit ? data_q[pc_idx][pc_off] : NOP;
  assign stall_o = req_i & ~hit;

  // Memory side: mem_req_o stays high for the whole refill; every cycle with mem_rvalid_i
  // high during REFILL consumes one beat, lowest word first. There is no backpressure.
  assign mem_req_o  = (state_q == REFILL);
  assign mem_addr_o = (state_q == REFILL) ? {line_q, {(OFF_W + 2){1'b0}}} : 32'd0;
  assign state_o    = state_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    valid_d = valid_q;
    data_we = 1'b0;
    tag_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && !hit) begin
          state_d         = REFILL;
          line_d          = {pc_tag, pc_idx};
          beat_d          = '0;
          valid_d[pc_idx] = 1'b0;
        end
      end
      REFILL: begin
        if (mem_rvalid_i) begin
          data_we = 1'b1;
          beat_d  = beat_q + OFF_W'(1);
          if (beat_q == LAST_BEAT) begin
            tag_we            = 1'b1;
            valid_d[line_idx] = 1'b1;
            beat_d            = '0;
            state_d           = FILLED;
          end
        end
      end
      FILLED:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      valid_q <= valid_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clk_i) begin
    if (!rst_i && data_we) data_q[line_idx][beat_q] <= mem_rdata_i;
    if (!rst_i && tag_we)  tag_q[line_idx] <= line_tag;
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: cold miss, hits, conflict, gapped memory,
// pc wandering during refill, reset mid-refill, stray rvalid while idle.
module tb_instr_cache;
  logic        clk = 1'b0;
  logic        rst_i, req_i, mem_rvalid_i;
  logic [31:0] pc_i, mem_rdata_i;
  logic [31:0] instr_o, mem_addr_o;
  logic        stall_o, mem_req_o;
  logic [1:0]  state_o;
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_cache #(.SETS(16), .WORDS(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .pc_i(pc_i),
    .instr_o(instr_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in the miss cycle with req_i/pc_i already driven. Returns in the retry cycle.
  task automatic refill(input logic [31:0] addr, input logic [31:0] d0, input int gap,
                        input bit wander);
    logic [31:0] pc_save;
    pc_save = pc_i;
    #1;
    chk("miss_stall", stall_o, 1);
    chk("miss_no_memreq_yet", mem_req_o, 0);
    step();
    chk("refill_state", state_o, 1);
    chk("refill_memreq", mem_req_o, 1);
    chk("refill_addr", mem_addr_o, addr);
    if (wander) begin
      req_i = 1'b0;
      pc_i  = 32'h0000_0998;
    end
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hBAD0_0000 + b;
        #1;
        chk("gap_memreq", mem_req_o, 1);
        chk("gap_addr", mem_addr_o, addr);
        step();
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = d0 + b;
      #1;
      chk("beat_memreq", mem_req_o, 1);
      if (!wander) chk("beat_stall", stall_o, 1);
      step();
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'hBAD1_1111;
    req_i        = 1'b1;
    pc_i         = pc_save;
    #1;
    chk("filled_state", state_o, 2);
    chk("filled_stall", stall_o, 1);
    chk("filled_memreq", mem_req_o, 0);
    step();
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; pc_i = 32'd0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    step();
    step();
    chk("rst_state", state_o, 0);
    chk("rst_memreq", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    rst_i = 1'b0;
    step();

    // Stray rvalid while idle and not requesting
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("idle_stray_stall", stall_o, 0);
    chk("idle_stray_instr", instr_o, NOP);
    step();
    chk("idle_stray_state", state_o, 0);
    chk("idle_stray_memreq", mem_req_o, 0);
    mem_rvalid_i = 1'b0;

    // Cold miss on 0x104 -> line 0x100, data A0..A3; hit in cycle 6
    req_i = 1'b1; pc_i = 32'h0000_0104;
    refill(32'h0000_0100, 32'h0000_00A0, 0, 1'b0);
    chk("cold_hit_stall", stall_o, 0);
    chk("cold_hit_instr", instr_o, 32'h0000_00A1);

    // Same-line hits back to back
    pc_i = 32'h0000_0100; #1;
    chk("hit100_instr", instr_o, 32'h0000_00A0);
    chk("hit100_stall", stall_o, 0);
    step();
    pc_i = 32'h0000_0108; #1;
    chk("hit108_instr", instr_o, 32'h0000_00A2);
    chk("hit108_memreq", mem_req_o, 0);
    step();
    pc_i = 32'h0000_010C; #1;
    chk("hit10c_instr", instr_o, 32'h0000_00A3);
    chk("hit10c_stall", stall_o, 0);
    chk("hit10c_memreq", mem_req_o, 0);
    step();

    // Conflict at index 0 with tag 2, then the old line misses again
    pc_i = 32'h0000_0204;
    refill(32'h0000_0200, 32'h0000_00B0, 0, 1'b0);
    chk("conflict_instr", instr_o, 32'h0000_00B1);
    step();
    pc_i = 32'h0000_0100;
    refill(32'h0000_0100, 32'h0000_00C0, 0, 1'b0);
    chk("refetch_instr", instr_o, 32'h0000_00C0);
    step();

    // Gapped memory: a beat every third cycle
    pc_i = 32'h0000_0314;
    refill(32'h0000_0310, 32'h0000_00D0, 2, 1'b0);
    chk("gap_hit314", instr_o, 32'h0000_00D1);
    step();
    pc_i = 32'h0000_0310; #1;
    chk("gap_hit310", instr_o, 32'h0000_00D0);
    step();
    pc_i = 32'h0000_031C; #1;
    chk("gap_hit31c", instr_o, 32'h0000_00D3);
    chk("gap_hit31c_stall", stall_o, 0);
    step();
    pc_i = 32'h0000_0108; #1;
    chk("other_index_hit", instr_o, 32'h0000_00C2);
    step();

    // pc_i/req_i wander during refill; the latched line still installs
    pc_i = 32'h0000_0420;
    refill(32'h0000_0420, 32'h0000_0050, 0, 1'b1);
    chk("wander_hit_instr", instr_o, 32'h0000_0050);
    chk("wander_hit_stall", stall_o, 0);
    step();

    // Reset after two beats of a refill
    pc_i = 32'h0000_0534; #1;
    chk("rstmid_miss", stall_o, 1);
    step();
    chk("rstmid_memreq", mem_req_o, 1);
    for (int b = 0; b < 2; b++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_00E0 + b;
      step();
    end
    mem_rvalid_i = 1'b0; rst_i = 1'b1; req_i = 1'b0;
    step();
    chk("rstmid_memreq_low", mem_req_o, 0);
    chk("rstmid_state", state_o, 0);
    chk("rstmid_addr", mem_addr_o, 0);
    rst_i = 1'b0;
    step();
    req_i = 1'b1; pc_i = 32'h0000_0100; #1;
    chk("post_rst_miss_100", stall_o, 1);
    chk("post_rst_nop", instr_o, NOP);
    pc_i = 32'h0000_0534;
    refill(32'h0000_0530, 32'h0000_00F0, 0, 1'b0);
    chk("rstmid_refill_instr", instr_o, 32'h0000_00F1);
    step();
    pc_i = 32'h0000_0538; #1;
    chk("rstmid_refill_w2", instr_o, 32'h0000_00F2);
    step();

    // Request dropped: no stall, NOP out
    req_i = 1'b0; #1;
    chk("noreq_stall", stall_o, 0);
    chk("noreq_instr", instr_o, NOP);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
